aukv_fetch_pq: RTL and testbench
================================

// Module: aukv_fetch_pq
// PURPOSE
//  Parametrised prefetching fetch unit for the Auk-V RV32I pipeline; replaces the single-buffer fetch stage.
//  Keeps up to MAX_OUTST instruction reads in flight and buffers returned words in a DEPTH-entry {pc,instr} queue.
//  Flushes the queue and squashes stale responses on branch/exception redirect.
//  Feeds decode with o_instr/o_pc/o_instr_valid; decode back-pressures with i_stall.
// PARAMETERS
//  DEPTH      4        prefetch queue entries; power of 2, >=2
//  MAX_OUTST  2        max outstanding memory reads, 1..DEPTH
//  RESET_PC   32'h0    first fetch address after reset
//  NOP_INSTR  32'h33   word driven on o_instr when no valid instruction (ADD x0,x0,x0)
// PORTS
//  i_clk               in   1   clock
//  i_rstn              in   1   async active-low reset
//  o_instr_addr        out  32  fetch address, word aligned
//  o_instr_addr_valid  out  1   fetch request valid
//  i_instr_addr_ready  in   1   memory accepts request (transfer = valid & ready)
//  i_instr_data        in   32  read data, returned in request order
//  i_instr_data_valid  in   1   read data valid, one per accepted request, latency >=1 cycle
//  i_stall             in   1   decode cannot accept; hold outputs
//  i_branch_en         in   1   branch redirect request
//  i_branch_addr       in   32  branch target
//  i_exception         in   1   exception redirect request
//  i_evec_addr         in   32  exception vector
//  o_pc                out  32  pc of o_instr
//  o_instr             out  32  instruction to decode
//  o_instr_valid       out  1   o_instr/o_pc valid
// BEHAVIOUR
//  Reset (i_rstn, asynchronous, active-low; clock i_clk): pc=RESET_PC; queue empty; outst=0; drop=0;
//   o_instr_valid=0, o_instr=NOP_INSTR, o_pc=0, o_instr_addr_valid=0 while i_rstn low.
//  redirect = i_exception | (i_branch_en & ~i_stall); target = i_exception ? i_evec_addr : i_branch_addr (exception wins).
//  Issue: o_instr_addr=pc; o_instr_addr_valid = ~redirect & (outst < MAX_OUTST) & (outst+count < DEPTH).
//   Credit rule guarantees every response has a free slot; queue never overflows.
//   On transfer pc <= pc+4 (mod 2^32 wrap); outst +1. No request is issued in the redirect cycle.
//  Response: if drop>0, word discarded, drop-1; else pushed with its pc (pc tracked by a response-pc counter).
//   Response every cycle sustains 1 instr/cycle; response with outst=0 is a protocol error (assertion).
//  Output: o_instr_valid = (count>0) & ~redirect; o_instr/o_pc = head entry, else NOP_INSTR/0.
//   Pop when o_instr_valid & ~i_stall. Stall holds o_instr/o_pc stable; queue refills behind it.
//  Redirect at cycle T: queue cleared; pc<=target; response-pc<=target;
//   drop <= drop + outst - (response at T), counting a response landing at T as discarded; o_instr_valid=0 at T.
//   Request to target at T+1; with 1-cycle memory, data at T+2, o_instr_valid=1 at T+3, o_pc=target.
//  Simultaneous issue+response: outst unchanged. Simultaneous push+pop: count unchanged.
//  Back-to-back redirects: the later target wins; drop accumulates.
//  i_branch_en while i_stall is ignored (decode re-presents it).
// CONFIGURATION
//  AUKV_FETCH_MISALIGN_EN defined: a target with [1:0]!=0 is not fetched. The unit holds a single
//   o_instr_valid=1 entry: o_instr=NOP_INSTR, o_pc=target, output o_instr_misalign=1, until the next redirect.
//  Not defined: port o_instr_misalign absent; target[1:0] forced to 0.
// STRUCTURE
//  aukv_defines.vh: AUKV_NOP_INSTR, AUKV_RESET_PC, AUKV_XLEN, log2 helper function.
//  Sub-module aukv_sync_fifo (WIDTH=64, DEPTH, synchronous flush, count output) holds {pc,instr}.
//  Top holds the pc/response-pc registers, the outst/drop counters and the redirect logic.
// TESTING
//  1 Reset, ready=1, 1-cycle memory -> addrs 0,4,8.. back-to-back; first o_instr_valid at cycle 3, o_pc=0, then 1/cycle.
//  2 i_stall high 6 cycles -> o_instr/o_pc frozen; issue halts at outst+count=DEPTH=4; no word lost after release.
//  3 Branch to 0x100 with 2 reads outstanding -> both responses dropped; next valid o_pc=0x100 with its word.
//  4 i_exception and i_branch_en same cycle, i_stall=1 -> pc<=i_evec_addr; the branch is ignored.
//  5 Random ready/latency (1..4) with random redirects -> scoreboard: every o_pc sequence from a target in +4 steps, never stale.
//  6 Branch to 0x102 with AUKV_FETCH_MISALIGN_EN -> o_instr_misalign=1, o_pc=0x102, no memory request.

Source files
------------

// File: rtl/aukv_fetch_pq_pkg.sv
// aukv_fetch_pq_pkg: shared constants and helpers for the Auk-V prefetching fetch unit.
package aukv_fetch_pq_pkg;
    localparam int          AUKV_XLEN      = 32;
    localparam logic [31:0] AUKV_NOP_INSTR = 32'h0000_0033;
    localparam logic [31:0] AUKV_RESET_PC  = 32'h0000_0000;

    function automatic int aukv_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/aukv_fetch_pq_sync_fifo.sv
// aukv_fetch_pq_sync_fifo: power-of-2 synchronous FIFO with flush and occupancy count.
module aukv_fetch_pq_sync_fifo
    import aukv_fetch_pq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int AW    = aukv_log2(DEPTH),
    parameter int CW    = aukv_log2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;

    always_ff @(posedge i_clk) if (push) mem[wp] <= wdata;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rp];
endmodule

// File: rtl/aukv_fetch_pq.sv
// aukv_fetch_pq: prefetching fetch unit with redirect squash; define AUKV_FETCH_MISALIGN_EN
// to report misaligned redirect targets through o_instr_misalign instead of aligning them.
module aukv_fetch_pq
    import aukv_fetch_pq_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = AUKV_RESET_PC,
    parameter logic [31:0] NOP_INSTR = AUKV_NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    output logic [31:0] o_instr_addr,
    output logic        o_instr_addr_valid,
    input  logic        i_instr_addr_ready,
    input  logic [31:0] i_instr_data,
    input  logic        i_instr_data_valid,
    input  logic        i_stall,
    input  logic        i_branch_en,
    input  logic [31:0] i_branch_addr,
    input  logic        i_exception,
    input  logic [31:0] i_evec_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_instr_valid
`ifdef AUKV_FETCH_MISALIGN_EN
   ,output logic        o_instr_misalign
`endif
);
    localparam int CW = aukv_log2(DEPTH) + 1;
    localparam int OW = aukv_log2(MAX_OUTST) + 1;

    logic [31:0]   pc, rsp_pc, target;
    logic [OW-1:0] outst;
    logic [7:0]    drop;
    logic [CW-1:0] count;
    logic [63:0]   head;
    logic          redirect, issue, rsp_live, rsp_dead, push, pop, mis;

    assign redirect = i_exception | (i_branch_en & ~i_stall);
`ifdef AUKV_FETCH_MISALIGN_EN
    assign target = i_exception ? i_evec_addr : i_branch_addr;

    // A misaligned target parks the unit on a single faulting entry until the next redirect.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) mis <= 1'b0;
        else if (redirect) mis <= |target[1:0];
    end

    assign o_instr_misalign = mis & o_instr_valid;
`else
    assign target = (i_exception ? i_evec_addr : i_branch_addr) & ~32'h3;
    assign mis    = 1'b0;
`endif

    // outst counts live requests only; squashed ones in flight move into drop.
    assign rsp_dead = i_instr_data_valid & (drop != '0);
    assign rsp_live = i_instr_data_valid & (drop == '0);
    assign push     = rsp_live & ~redirect;

    assign o_instr_addr       = pc;
    assign o_instr_addr_valid = i_rstn & ~redirect & ~mis & (outst < OW'(MAX_OUTST))
                              & (int'(outst) + int'(count) < DEPTH);
    assign issue              = o_instr_addr_valid & i_instr_addr_ready;

    assign o_instr_valid = ~redirect & (mis | (count != '0));
    assign o_instr       = (o_instr_valid & ~mis) ? head[31:0] : NOP_INSTR;
    assign o_pc          = !o_instr_valid ? '0 : (mis ? pc : head[63:32]);
    assign pop           = o_instr_valid & ~i_stall & ~mis;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pc     <= RESET_PC;
            rsp_pc <= RESET_PC;
            outst  <= '0;
            drop   <= '0;
        end else if (redirect) begin
            pc     <= target;
            rsp_pc <= target;
            outst  <= '0;
            drop   <= drop + 8'(outst) - 8'(i_instr_data_valid);
        end else begin
            pc     <= issue ? pc + 32'd4 : pc;
            rsp_pc <= push ? rsp_pc + 32'd4 : rsp_pc;
            outst  <= outst + OW'(issue) - OW'(rsp_live);
            drop   <= drop - 8'(rsp_dead);
        end
    end

    always_ff @(posedge i_clk) if (i_rstn) assert (!(i_instr_data_valid && outst == '0 && drop == '0));

    aukv_fetch_pq_sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .flush  (redirect),
        .push   (push),
        .pop    (pop),
        .wdata  ({rsp_pc, i_instr_data}),
        .rdata  (head),
        .count  (count)
    );
endmodule

// File: tb/tb_aukv_fetch_pq.sv
// tb_aukv_fetch_pq: directed and randomized checks of aukv_fetch_pq against an in-order memory model.
module tb_aukv_fetch_pq;
    logic        i_clk = 1'b0, i_rstn = 1'b0;
    logic [31:0] o_instr_addr, i_instr_data = '0, i_branch_addr = '0, i_evec_addr = '0;
    logic [31:0] o_pc, o_instr;
    logic        o_instr_addr_valid, i_instr_addr_ready = 1'b1, i_instr_data_valid = 1'b0;
    logic        i_stall = 1'b0, i_branch_en = 1'b0, i_exception = 1'b0, o_instr_valid;
`ifdef AUKV_FETCH_MISALIGN_EN
    logic        o_instr_misalign;
`endif
    int tests = 0, fails = 0, cyc = 0, lat_min = 1, lat_max = 1, pops = 0;
    bit rnd_ready = 0, found;
    logic [31:0] exp_pc;

    typedef struct {logic [31:0] addr; int due;} req_t;
    req_t mq[$];

    aukv_fetch_pq dut (
        .i_clk              (i_clk),
        .i_rstn             (i_rstn),
        .o_instr_addr       (o_instr_addr),
        .o_instr_addr_valid (o_instr_addr_valid),
        .i_instr_addr_ready (i_instr_addr_ready),
        .i_instr_data       (i_instr_data),
        .i_instr_data_valid (i_instr_data_valid),
        .i_stall            (i_stall),
        .i_branch_en        (i_branch_en),
        .i_branch_addr      (i_branch_addr),
        .i_exception        (i_exception),
        .i_evec_addr        (i_evec_addr),
        .o_pc               (o_pc),
        .o_instr            (o_instr),
        .o_instr_valid      (o_instr_valid)
`ifdef AUKV_FETCH_MISALIGN_EN
       ,.o_instr_misalign   (o_instr_misalign)
`endif
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // In-order memory: a request accepted at posedge u answers for posedge u+latency, data = ~addr.
    always @(negedge i_clk) begin
        i_instr_data_valid = 1'b0;
        i_instr_addr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!i_rstn) mq.delete();
        else begin
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                i_instr_data_valid = 1'b1;
                i_instr_data       = ~mq[0].addr;
                void'(mq.pop_front());
            end
            if (o_instr_addr_valid && i_instr_addr_ready)
                mq.push_back('{o_instr_addr, cyc + 1 + int'($urandom_range(lat_min, lat_max))});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(o_instr_valid), 32'd1);
        chk({tag, "_pc"}, o_pc, pc);
        chk({tag, "_instr"}, o_instr, ~pc);
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #2;
        chk("rst_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_instr", o_instr, 32'h33);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_addr_valid", 32'(o_instr_addr_valid), 32'd0);
        nxt(); i_rstn = 1'b1; #1;
        chk("boot_addr", o_instr_addr, 32'd0);
        chk("boot_addr_valid", 32'(o_instr_addr_valid), 32'd1);
        nxt(); #1;
        chk("boot_no_valid", 32'(o_instr_valid), 32'd0);
        chk("boot_addr4", o_instr_addr, 32'd4);
        nxt(); #1;
        chk_head("first", 32'd0);
        chk("first_addr", o_instr_addr, 32'd8);
        for (int k = 1; k <= 4; k++) begin
            nxt(); #1;
            chk_head("stream", 32'(4 * k));
        end
        // stall: head frozen at 0x10, issue stops once queue + in-flight reach DEPTH
        i_stall = 1'b1; #1;
        chk_head("stall0", 32'h10);
        for (int k = 0; k < 6; k++) begin
            nxt(); #1;
            chk_head("stall", 32'h10);
        end
        chk("stall_issue_halt", 32'(o_instr_addr_valid), 32'd0);
        chk("stall_addr", o_instr_addr, 32'h20);
        i_stall = 1'b0; #1;
        chk_head("release0", 32'h10);
        exp_pc = 32'h10;
        for (int k = 0; k < 8; k++) begin
            exp_pc += 4;
            nxt(); #1;
            chk_head("release", exp_pc);
        end
        // branch with slow memory so two reads are in flight
        lat_min = 4; lat_max = 4;
        repeat (4) nxt();
        i_branch_en = 1'b1; i_branch_addr = 32'h100; #1;
        chk("br_valid_low", 32'(o_instr_valid), 32'd0);
        nxt(); i_branch_en = 1'b0; lat_min = 1; lat_max = 1; #1;
        chk("br_addr", o_instr_addr, 32'h100);
        chk("br_addr_valid", 32'(o_instr_addr_valid), 32'd1);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (o_instr_valid) found = 1;
            else begin nxt(); #1; end
        end
        chk("br_timeout", 32'(found), 32'd1);
        chk_head("br_first", 32'h100);
        nxt(); #1;
        chk_head("br_second", 32'h104);
        // stalled branch is ignored
        i_stall = 1'b1; i_branch_en = 1'b1; i_branch_addr = 32'h300; #1;
        chk_head("stbr", 32'h104);
        nxt(); #1;
        chk_head("stbr_hold", 32'h104);
        // exception wins over branch, even under stall
        i_exception = 1'b1; i_evec_addr = 32'h200; #1;
        chk("exc_valid_low", 32'(o_instr_valid), 32'd0);
        nxt(); i_exception = 1'b0; i_branch_en = 1'b0; i_stall = 1'b0; #1;
        chk("exc_addr", o_instr_addr, 32'h200);
        chk("exc_addr_valid", 32'(o_instr_addr_valid), 32'd1);
        nxt(); #1;
        chk("exc_t2_valid", 32'(o_instr_valid), 32'd0);
        nxt(); #1;
        chk_head("exc_t3", 32'h200);
        nxt(); #1;
        chk_head("exc_t4", 32'h204);
        // pc wraps modulo 2^32
        i_branch_en = 1'b1; i_branch_addr = 32'hFFFF_FFF8; #1;
        chk("wrap_valid_low", 32'(o_instr_valid), 32'd0);
        nxt(); i_branch_en = 1'b0;
        nxt(); nxt(); #1;
        chk_head("wrap0", 32'hFFFF_FFF8);
        nxt(); #1; chk_head("wrap1", 32'hFFFF_FFFC);
        nxt(); #1; chk_head("wrap2", 32'h0);
        nxt(); #1; chk_head("wrap3", 32'h4);
        // misaligned target
        i_branch_en = 1'b1; i_branch_addr = 32'h102; #1;
        chk("mis_valid_low", 32'(o_instr_valid), 32'd0);
        nxt(); i_branch_en = 1'b0; #1;
`ifdef AUKV_FETCH_MISALIGN_EN
        chk("mis_no_req", 32'(o_instr_addr_valid), 32'd0);
        nxt(); nxt(); #1;
        chk("mis_valid", 32'(o_instr_valid), 32'd1);
        chk("mis_pc", o_pc, 32'h102);
        chk("mis_instr", o_instr, 32'h33);
        chk("mis_flag", 32'(o_instr_misalign), 32'd1);
        chk("mis_still_no_req", 32'(o_instr_addr_valid), 32'd0);
`else
        chk("align_addr", o_instr_addr, 32'h100);
        nxt(); nxt(); #1;
        chk_head("align0", 32'h100);
        nxt(); #1;
        chk_head("align1", 32'h104);
`endif
        // random ready/latency/stall/redirect against a pc scoreboard
        rnd_ready = 1; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 500; i++) begin
            nxt();
            i_stall       = (i != 0) && ($urandom_range(0, 3) == 0);
            i_exception   = (i != 0) && ($urandom_range(0, 40) == 0);
            i_branch_en   = (i == 0) || ($urandom_range(0, 15) == 0);
            i_evec_addr   = 32'h2000 + 32'($urandom_range(0, 63)) * 4;
            i_branch_addr = (i == 0) ? 32'h1000 : 32'h3000 + 32'($urandom_range(0, 63)) * 4;
            #1;
            if (i_exception || (i_branch_en && !i_stall)) begin
                exp_pc = i_exception ? i_evec_addr : i_branch_addr;
                chk("rnd_redir_valid", 32'(o_instr_valid), 32'd0);
            end else if (o_instr_valid && !i_stall) begin
                chk_head("rnd", exp_pc);
                exp_pc += 4;
                pops++;
            end
        end
        nxt();
        i_stall = 1'b0; i_exception = 1'b0; i_branch_en = 1'b0;
        chk("rnd_progress", 32'(pops > 50), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
